// File: rtl/pipelined_adder.sv
// pipelined_adder: N-bit add/subtract with NZCV flags. The carry chain is cut
// into STAGES slices of W = N/STAGES bits; each slice gets one register stage,
// so the critical path is one W-bit adder. Valid/ready handshake on both sides
// with a single global advance (no bubble collapsing).
//
// Optional feature macro: PIPE_ADD_SAT_EN
//   defined   : sat=1 clamps s to the signed limit on overflow (final stage).
//   undefined : sat is ignored and no clamp logic exists.

// One W-bit carry-chain slice.
module pipelined_adder_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
endmodule

module pipelined_adder #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    input  logic         c_in,
    input  logic         use_cin,
    input  logic         sat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         c_out,
    output logic         v,
    output logic         z,
    output logic         n
);
    localparam int W = N / STAGES;

    if (STAGES < 1 || (N % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_adder: N must be a non-zero multiple of STAGES");
    end

    logic              en;
    logic [STAGES:0]   vld_pipe;   // [0] = input side, [k] = op held in register k
    logic [N-1:0]      b_eff;
    logic              cin_eff;

    // Whole pipe advances together; a stalled output freezes everything.
    assign en        = !vld_pipe[STAGES] || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_pipe[STAGES];

    assign b_eff       = sub ? ~b : b;
    assign cin_eff     = use_cin ? c_in : sub;
    assign vld_pipe[0] = in_valid;

    // Valid shift register; reset drops every in-flight op at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_pipe[STAGES:1] <= '0;
        else if (en)
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    // Stage k adds slice k. Its operands arrive already shifted so the slice
    // to consume is always the low W bits (skew pipeline); completed lower
    // sum slices ride along in sum_all (deskew pipeline).
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic [(STAGES-k)*W-1:0] a_op;
        logic [(STAGES-k)*W-1:0] b_op;
        logic                    ci;
        logic [W-1:0]            ssum;
        logic                    sco;
        logic [(k+1)*W-1:0]      sum_all;
`ifdef PIPE_ADD_SAT_EN
        logic                    sat_op;
`endif

        if (k == 0) begin : g_in
            assign a_op    = a;
            assign b_op    = b_eff;
            assign ci      = cin_eff;
            assign sum_all = ssum;
`ifdef PIPE_ADD_SAT_EN
            assign sat_op  = sat;
`endif
        end else begin : g_reg
            logic [(STAGES-k)*W-1:0] a_q;
            logic [(STAGES-k)*W-1:0] b_q;
            logic [k*W-1:0]          sum_q;
            logic                    cy_q;
`ifdef PIPE_ADD_SAT_EN
            logic                    sat_q;
`endif

            // Register between slice k-1 and slice k; loads only real ops.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sum_q <= '0;
                    cy_q  <= 1'b0;
`ifdef PIPE_ADD_SAT_EN
                    sat_q <= 1'b0;
`endif
                end else if (en && vld_pipe[k-1]) begin
                    a_q   <= g_stg[k-1].a_op[(STAGES-k+1)*W-1:W];
                    b_q   <= g_stg[k-1].b_op[(STAGES-k+1)*W-1:W];
                    sum_q <= g_stg[k-1].sum_all;
                    cy_q  <= g_stg[k-1].sco;
`ifdef PIPE_ADD_SAT_EN
                    sat_q <= g_stg[k-1].sat_op;
`endif
                end
            end

            assign a_op    = a_q;
            assign b_op    = b_q;
            assign ci      = cy_q;
            assign sum_all = {ssum, sum_q};
`ifdef PIPE_ADD_SAT_EN
            assign sat_op  = sat_q;
`endif
        end

        pipelined_adder_slice #(.W(W)) u_slice (
            .a  (a_op[W-1:0]),
            .b  (b_op[W-1:0]),
            .ci (ci),
            .s  (ssum),
            .co (sco)
        );
    end

    // Final-stage result: sign bits of the last slice give overflow.
    logic [N-1:0] s_raw;
    logic [N-1:0] s_fin;
    logic         a_msb;
    logic         b_msb;
    logic         ovf;

    assign s_raw = g_stg[STAGES-1].sum_all;
    assign a_msb = g_stg[STAGES-1].a_op[W-1];
    assign b_msb = g_stg[STAGES-1].b_op[W-1];
    assign ovf   = (a_msb == b_msb) && (s_raw[N-1] != a_msb);

`ifdef PIPE_ADD_SAT_EN
    // Clamp toward the sign of A on overflow; carry stays raw.
    always_comb begin
        s_fin = s_raw;
        if (g_stg[STAGES-1].sat_op && ovf)
            s_fin = a_msb ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
`else
    logic unused_sat;
    assign unused_sat = sat;
    assign s_fin      = s_raw;
`endif

    // Output register; flags derive from the value actually driven on s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s     <= '0;
            c_out <= 1'b0;
            v     <= 1'b0;
            z     <= 1'b0;
            n     <= 1'b0;
        end else if (!en) begin
            // stall: hold everything
        end else if (vld_pipe[STAGES-1]) begin
            s     <= s_fin;
            c_out <= g_stg[STAGES-1].sco;
            v     <= ovf;
            z     <= ~|s_fin;
            n     <= s_fin[N-1];
        end else begin
            // bubble: clear flags so a retired result never lingers
            s     <= '0;
            c_out <= 1'b0;
            v     <= 1'b0;
            z     <= 1'b0;
            n     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed vectors for pipelined_adder (N=32, STAGES=4).
// Expected values are hand-computed; PIPE_ADD_SAT_EN selects the clamp cases.
module tb_pipelined_adder;
    localparam int N      = 32;
    localparam int STAGES = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         c_in;
    logic         use_cin;
    logic         sat;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         c_out;
    logic         v;
    logic         z;
    logic         n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipelined_adder #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .c_in      (c_in),
        .use_cin   (use_cin),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out),
        .v         (v),
        .z         (z),
        .n         (n)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op (called at posedge+1 with out_ready=1), then check latency,
    // result and {c,v,z,n}.
    task automatic do_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                         input logic isub, input logic icin, input logic iuse, input logic isat,
                         input logic [31:0] es, input logic [3:0] ef);
        int lat;
        a = ia; b = ib; sub = isub; c_in = icin; use_cin = iuse; sat = isat;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".lat"},  64'(lat), 64'(STAGES));
        chk({tag, ".s"},    64'(s), 64'(es));
        chk({tag, ".cvzn"}, 64'({c_out, v, z, n}), 64'(ef));
    endtask

    initial begin
        int           issued;
        int           rx;
        int           first;
        int           last;
        int           extra;
        logic         acc_in;
        logic [N-1:0] held_s;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
        c_in = 1'b0; use_cin = 1'b0; sat = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.out_valid", 64'(out_valid), 64'(0));
        chk("rst.in_ready",  64'(in_ready), 64'(1));
        chk("rst.s",         64'(s), 64'(0));
        chk("rst.cvzn",      64'({c_out, v, z, n}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed single ops
        do_op("add_cross",  32'h0000FFFF, 32'h00000001, 0, 0, 0, 0, 32'h00010000, 4'b0000);
        do_op("sub_eq",     32'd5, 32'd5, 1, 0, 0, 0, 32'h00000000, 4'b1010);
        do_op("sub_neg",    32'd3, 32'd5, 1, 0, 0, 0, 32'hFFFFFFFE, 4'b0001);
        do_op("add_ovf",    32'h7FFFFFFF, 32'h00000001, 0, 0, 0, 0, 32'h80000000, 4'b0101);
        do_op("adc_wrap",   32'hFFFFFFFF, 32'h00000000, 0, 1, 1, 0, 32'h00000000, 4'b1010);
        do_op("sbc",        32'd7, 32'd2, 1, 0, 1, 0, 32'h00000004, 4'b1000);
        do_op("sat_no_ovf", 32'd1, 32'd1, 0, 0, 0, 1, 32'h00000002, 4'b0000);
`ifdef PIPE_ADD_SAT_EN
        do_op("sat_pos",    32'h7FFFFFFF, 32'h00000001, 0, 0, 0, 1, 32'h7FFFFFFF, 4'b0100);
        do_op("sat_neg",    32'h80000000, 32'h00000001, 1, 0, 0, 1, 32'h80000000, 4'b1101);
`else
        do_op("sat_pos",    32'h7FFFFFFF, 32'h00000001, 0, 0, 0, 1, 32'h80000000, 4'b0101);
        do_op("sat_neg",    32'h80000000, 32'h00000001, 1, 0, 0, 1, 32'h7FFFFFFF, 4'b1100);
`endif

        // Let the last result retire before streaming
        @(posedge clk); #1;

        // 8 back-to-back adds (i + 0x100), out_ready low in cycles 6..8
        issued = 0; rx = 0; first = -1; last = -1; held_s = '0;
        for (int t = 0; t < 60 && rx < 8; t++) begin
            out_ready = !(t >= 6 && t <= 8);
            in_valid  = (issued < 8);
            a = 32'(issued); b = 32'h100; sub = 1'b0; c_in = 1'b0; use_cin = 1'b0; sat = 1'b0;
            @(negedge clk);
            if (!out_ready) begin
                chk("stall.in_ready",  64'(in_ready), 64'(0));
                chk("stall.out_valid", 64'(out_valid), 64'(1));
                if (t > 6) chk("stall.s_hold", 64'(s), 64'(held_s));
            end
            acc_in = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk($sformatf("stream.s%0d", rx), 64'(s), 64'(32'h100 + 32'(rx)));
                if (first < 0) first = t;
                last = t;
                rx++;
            end
            held_s = s;
            @(posedge clk); #1;
            if (acc_in) issued++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream.count", 64'(rx), 64'(8));
        chk("stream.span",  64'(last - first), 64'(10));
        chk("stream.first", 64'(first), 64'(4));
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) extra++;
            @(posedge clk); #1;
        end
        chk("stream.no_dup", 64'(extra), 64'(0));

        // Async reset with ops in flight: A on the output, B..D inside
        a = 32'h7FFFFFFF; b = 32'h1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'd10; b = 32'd20;
        @(posedge clk); #1;
        a = 32'd30; b = 32'd40;
        @(posedge clk); #1;
        a = 32'd50; b = 32'd60;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst.out_valid", 64'(out_valid), 64'(1));
        chk("pre_rst.cvzn",      64'({c_out, v, z, n}), 64'(4'b0101));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.out_valid", 64'(out_valid), 64'(0));
        chk("async_rst.s",         64'(s), 64'(0));
        chk("async_rst.cvzn",      64'({c_out, v, z, n}), 64'(0));
        chk("async_rst.in_ready",  64'(in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        chk("post_rst.no_stale", 64'(extra), 64'(0));
        do_op("post_rst", 32'h12345678, 32'h11111111, 0, 0, 0, 0, 32'h23456789, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined N-bit integer add/subtract unit with NZCV flags. Splits the carry chain into STAGES equal slices, one register stage per slice, to close timing at wide N. Uses a valid/ready handshake on both sides. Sits in the ALU datapath as the successor to the single-cycle combinational adder, for multi-cycle execute paths and wide-datapath configurations.

## Interface
- N, default 32 — operand/result width; must be a multiple of STAGES.
- STAGES, default 4 — pipeline depth and carry-slice count; W = N/STAGES bits per slice; STAGES ≥ 1.
- clk  in  1  — single clock; all state updates on the rising edge.
- rst_n  in  1  — asynchronous, active-low reset.
- in_valid  in  1  — operation presented on a/b/sub/c_in/use_cin/sat.
- in_ready  out  1  — unit accepts an operation this cycle.
- a  in  N  — operand A.
- b  in  N  — operand B.
- sub  in  1  — 1: A − B (B inverted); 0: A + B.
- c_in  in  1  — external carry-in.
- use_cin  in  1  — 1: carry-in is c_in (ADC/SBC); 0: carry-in is sub.
- sat  in  1  — request signed saturation; ignored unless PIPE_ADD_SAT_EN is defined.
- out_valid  out  1  — result and flags valid.
- out_ready  in  1  — consumer accepts the result.
- s  out  N  — result.
- c_out  out  1  — carry out of bit N−1. For subtract, 1 = no borrow.
- v  out  1  — signed overflow.
- z  out  1  — result is all zero.
- n  out  1  — result bit N−1.

## Operation
- Effective operand: b_eff = sub ? ~b : b. Effective carry-in: cin_eff = use_cin ? c_in : sub.
- Stage k (0..STAGES−1) adds slice k of a and b_eff plus the carry registered from stage k−1 (stage 0 uses cin_eff).
  - Each slice's W-bit sum and carry are registered.
  - Unconsumed upper slices of a and b_eff travel forward in a skew pipeline.
  - Completed lower sum slices travel forward in a deskew pipeline.
- c_out is the carry out of slice STAGES−1.
- v = (a[N−1] == b_eff[N−1]) && (s_raw[N−1] != a[N−1]).
- z = (s == 0) over all N bits. n = s[N−1]. Flags are always computed from the final driven s.
- Each stage carries a valid bit and operation sideband (sat).
- Global advance: en = !out_valid || out_ready. in_ready = en. All stages shift together when en is high.
- Bubbles are not collapsed, but throughput is one operation per cycle while out_ready stays high.
- Ops retire in issue order. No op is dropped or duplicated.

## Timing
- Latency: exactly STAGES cycles from the accepting edge (in_valid && in_ready) to out_valid, given no stall.
- STAGES=1 degenerates to a registered single-cycle adder with latency 1.
- Stall (out_valid && !out_ready):
  - s, c_out, v, z, n and out_valid hold stable.
  - in_ready = 0 in the same cycle (combinational from out_ready).
  - Inputs are not sampled.
- A transfer on each side completes when valid && ready are high at the edge. in_valid may be asserted independent of in_ready.
- Reset:
  - All valid bits, s, c_out, v, z and n reset to 0.
  - in_ready = 1 from reset release.
  - Asserting rst_n mid-operation discards all in-flight ops immediately (asynchronously). No stale result appears after release.

## Configuration
- PIPE_ADD_SAT_EN defined: when sat=1 and raw overflow occurs, s clamps.
  - Positive overflow (a[N−1]=0): s = {0, {N−1{1}}}.
  - Negative overflow: s = {1, {N−1{0}}}.
  - v still reports 1. c_out is unchanged (raw carry). z and n follow the clamped s.
  - Clamping is applied in the final stage; latency is unchanged.
- Not defined: sat is ignored, s is always the raw wrapped sum, and no clamp logic is synthesised.

## Test plan
- N=32, STAGES=4, add, 0x0000FFFF + 0x00000001 -> 4 cycles later s=0x00010000, c=0 v=0 z=0 n=0 (carry crosses slice boundary).
- sub, 5 − 5 -> s=0x00000000, c=1 z=1 v=0 n=0. Then sub, 3 − 5 -> s=0xFFFFFFFE, c=0 n=1 v=0.
- add, 0x7FFFFFFF + 1 -> s=0x80000000, v=1 n=1 c=0.
  - With PIPE_ADD_SAT_EN and sat=1 -> s=0x7FFFFFFF, v=1, n=0.
  - Without the macro and sat=1 -> s=0x80000000.
- use_cin=1, c_in=1, 0xFFFFFFFF + 0 -> s=0, c=1, z=1. use_cin=1, sub=1, c_in=0, 7 − 2 -> s=4, c=1.
- 8 back-to-back ops with out_ready=1 -> 8 results on 8 consecutive cycles, in order.
  - Drop out_ready for 3 cycles mid-stream -> outputs frozen, in_ready=0, no loss or duplication after resume.
- Drop rst_n with 3 ops in flight -> out_valid=0 and all flags 0 immediately. After release, first out_valid occurs only 4 cycles after a new accepted op.
